tour_cmd: RTL and testbench

//  Sequences cmd_proc during a knight's tour. On tour_go it walks the solved move list (indexed by mv_indx)
//  and splits each L-shaped knight move into two legs: a vertical move cmd, then a horizontal move+fanfare cmd.
//  It owns the cmd/cmd_rdy mux into cmd_proc. When no tour is running, UART/BLE commands pass straight through.
//  It also supplies the response byte that the UART wrapper sends on each send_resp.

---
 rtl/tour_pkg.sv | 30 +++
 rtl/tour_cmd_if.sv | 21 ++
 rtl/tour_move_decode.sv | 32 +++
 rtl/tour_cmd.sv | 138 +++++++++++++
 tb/tb_tour_cmd.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tour_pkg.sv
// Shared types and constants for the knight's-tour command sequencer.
package tour_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    VERT,
    WAIT_V,
    HORZ,
    WAIT_H
  } tour_state_t;

  localparam logic [7:0] HDG_N = 8'h00;
  localparam logic [7:0] HDG_W = 8'h3F;
  localparam logic [7:0] HDG_S = 8'h7F;
  localparam logic [7:0] HDG_E = 8'hBF;

  localparam logic [3:0] OP_MOVE    = 4'h2;
  localparam logic [3:0] OP_MOVE_FF = 4'h3;

  localparam logic [7:0] RESP_ACK  = 8'hA5;
  localparam logic [7:0] RESP_DONE = 8'h5A;

  // cmd layout: opcode[15:12], heading[11:4], bit 3 zero, squares[2:0]
  function automatic logic [15:0] mk_cmd(input logic [3:0] op, input logic [7:0] hdg,
                                         input logic [2:0] sq);
    return {op, hdg, 1'b0, sq};
  endfunction

endpackage

// File: rtl/tour_cmd_if.sv
// Command/response bundle between the UART wrapper, tour_cmd and cmd_proc.
interface tour_cmd_if;
  logic [15:0] cmd_UART;
  logic        cmd_rdy_UART;
  logic        clr_cmd_rdy_UART;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic        send_resp;
  logic [7:0]  resp;

  modport master (
    input  cmd_UART, cmd_rdy_UART, clr_cmd_rdy, send_resp,
    output cmd, cmd_rdy, clr_cmd_rdy_UART, resp
  );

  modport slave (
    output cmd_UART, cmd_rdy_UART, clr_cmd_rdy, send_resp,
    input  cmd, cmd_rdy, clr_cmd_rdy_UART, resp
  );
endinterface

// File: rtl/tour_move_decode.sv
// Splits a one-hot knight move into a vertical leg and a horizontal leg.
module tour_move_decode
  import tour_pkg::*;
(
  input  logic [7:0] move_reg,
  output logic [7:0] vhdg,
  output logic [2:0] vsq,
  output logic [7:0] hhdg,
  output logic [2:0] hsq,
  output logic       valid
);

  always_comb begin
    vhdg  = HDG_N;
    vsq   = 3'd0;
    hhdg  = HDG_E;
    hsq   = 3'd0;
    valid = $onehot(move_reg);
    case (move_reg)
      8'h01: begin vhdg = HDG_N; vsq = 3'd2; hhdg = HDG_E; hsq = 3'd1; end
      8'h02: begin vhdg = HDG_N; vsq = 3'd2; hhdg = HDG_W; hsq = 3'd1; end
      8'h04: begin vhdg = HDG_N; vsq = 3'd1; hhdg = HDG_W; hsq = 3'd2; end
      8'h08: begin vhdg = HDG_S; vsq = 3'd1; hhdg = HDG_W; hsq = 3'd2; end
      8'h10: begin vhdg = HDG_S; vsq = 3'd2; hhdg = HDG_W; hsq = 3'd1; end
      8'h20: begin vhdg = HDG_S; vsq = 3'd2; hhdg = HDG_E; hsq = 3'd1; end
      8'h40: begin vhdg = HDG_S; vsq = 3'd1; hhdg = HDG_E; hsq = 3'd2; end
      8'h80: begin vhdg = HDG_N; vsq = 3'd1; hhdg = HDG_E; hsq = 3'd2; end
      default: ;
    endcase
  end

endmodule

// File: rtl/tour_cmd.sv
// Walks the solved knight's tour, issuing a vertical then a horizontal cmd per move,
// and muxes tour commands with UART commands into cmd_proc.
module tour_cmd
  import tour_pkg::*;
#(
  parameter int NUM_MOVES = 24,
  parameter int IDX_W     = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_tour,
  input  logic [7:0]       move,
  output logic [IDX_W-1:0] mv_indx,
  tour_cmd_if.master       bus
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_MOVES - 1);

  tour_state_t      state_q, state_d;
  logic [IDX_W-1:0] mv_indx_q, mv_indx_d;
  logic [7:0]       move_reg_q, move_reg_d;
  logic             rdy_q, rdy_d;
  logic [7:0]       resp_q, resp_d;

  logic [7:0]  dec_in;
  logic [7:0]  vhdg, hhdg;
  logic [2:0]  vsq, hsq;
  logic        dec_valid;
  logic [15:0] tour_cmd_w;

  // In LOAD the fresh memory word is checked before it is latched, so a bad move aborts in that cycle
  assign dec_in = (state_q == LOAD) ? move : move_reg_q;

  tour_move_decode u_decode (
    .move_reg (dec_in),
    .vhdg     (vhdg),
    .vsq      (vsq),
    .hhdg     (hhdg),
    .hsq      (hsq),
    .valid    (dec_valid)
  );

  always_comb begin
    state_d    = state_q;
    mv_indx_d  = mv_indx_q;
    move_reg_d = move_reg_q;
    rdy_d      = rdy_q;
    case (state_q)
      IDLE: begin
        if (start_tour) begin
          mv_indx_d = '0;
          state_d   = LOAD;
        end
      end
      LOAD: begin
        move_reg_d = move;
        if (dec_valid) begin
          rdy_d   = 1'b1;
          state_d = VERT;
        end else begin
          state_d = IDLE;
        end
      end
      VERT: begin
        if (bus.clr_cmd_rdy) begin
          rdy_d   = 1'b0;
          state_d = WAIT_V;
        end
      end
      WAIT_V: begin
        if (bus.send_resp) begin
          rdy_d   = 1'b1;
          state_d = HORZ;
        end
      end
      HORZ: begin
        if (bus.clr_cmd_rdy) begin
          rdy_d   = 1'b0;
          state_d = WAIT_H;
        end
      end
      WAIT_H: begin
        if (bus.send_resp) begin
          if (mv_indx_q == LAST_IDX) begin
            state_d = IDLE;
          end else begin
            mv_indx_d = mv_indx_q + 1'b1;
            state_d   = LOAD;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Registered response tracks the state being entered
    resp_d = ((state_d == WAIT_H) && (mv_indx_d == LAST_IDX)) ? RESP_DONE : RESP_ACK;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      mv_indx_q  <= '0;
      move_reg_q <= '0;
      rdy_q      <= 1'b0;
      resp_q     <= RESP_ACK;
    end else begin
      state_q    <= state_d;
      mv_indx_q  <= mv_indx_d;
      move_reg_q <= move_reg_d;
      rdy_q      <= rdy_d;
      resp_q     <= resp_d;
    end
  end

  always_comb begin
    if ((state_q == HORZ) || (state_q == WAIT_H)) begin
      tour_cmd_w = mk_cmd(OP_MOVE_FF, hhdg, hsq);
    end else begin
      tour_cmd_w = mk_cmd(OP_MOVE, vhdg, vsq);
    end
  end

  always_comb begin
    if (state_q == IDLE) begin
      bus.cmd              = bus.cmd_UART;
      bus.cmd_rdy          = bus.cmd_rdy_UART;
      bus.clr_cmd_rdy_UART = bus.clr_cmd_rdy;
    end else begin
      bus.cmd              = tour_cmd_w;
      bus.cmd_rdy          = rdy_q;
      bus.clr_cmd_rdy_UART = 1'b0;
    end
  end

  assign bus.resp = resp_q;
  assign mv_indx  = mv_indx_q;

endmodule

// File: tb/tb_tour_cmd.sv
// Randomized bench for tour_cmd: a cmd_proc emulator drives the handshake while a
// knight-move model predicts each leg's command, the responses and mv_indx.
module tb_tour_cmd;

  localparam int NUM_MOVES = 24;
  localparam int M_OFF = 0, M_IDLE = 1, M_TRANS = 2, M_CMD = 3, M_WAIT = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_tour = 1'b0;
  logic [7:0] move;
  logic [4:0] mv_indx;
  logic [7:0] mem [32];

  tour_cmd_if bus ();

  tour_cmd #(.NUM_MOVES(NUM_MOVES), .IDX_W(5)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_tour (start_tour),
    .move       (move),
    .mv_indx    (mv_indx),
    .bus        (bus)
  );

  always #10 clk = ~clk;

  assign move = mem[mv_indx];

  int checks = 0;
  int errors = 0;
  int mode = M_IDLE;
  int exp_idx = 0;
  logic [15:0] exp_cmd;
  logic [7:0]  exp_resp;
  logic [15:0] seen_cmds[$];
  logic [7:0]  seen_resp[$];

  // Knight displacement per move bit: +dy is north, +dx is east
  int dx_t [8] = '{1, -1, -2, -2, -1, 1, 2, 2};
  int dy_t [8] = '{2, 2, 1, -1, -2, -2, -1, 1};

  function automatic logic [15:0] vcmd(input int b);
    int dy;
    dy = dy_t[b];
    return {4'h2, (dy > 0) ? 8'h00 : 8'h7F, 4'((dy > 0) ? dy : -dy)};
  endfunction

  function automatic logic [15:0] hcmd(input int b);
    int dx;
    dx = dx_t[b];
    return {4'h3, (dx > 0) ? 8'hBF : 8'h3F, 4'((dx > 0) ? dx : -dx)};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    case (mode)
      M_IDLE: begin
        chk("idle_cmd", bus.cmd, bus.cmd_UART);
        chk("idle_rdy", bus.cmd_rdy, bus.cmd_rdy_UART);
        chk("idle_clr", bus.clr_cmd_rdy_UART, bus.clr_cmd_rdy);
        chk("idle_resp", bus.resp, 8'hA5);
        chk("idle_idx", mv_indx, exp_idx);
      end
      M_TRANS: chk("trans_clr_uart", bus.clr_cmd_rdy_UART, 1'b0);
      M_CMD: begin
        chk("cmd_rdy", bus.cmd_rdy, 1'b1);
        chk("cmd_val", bus.cmd, exp_cmd);
        chk("cmd_clr_uart", bus.clr_cmd_rdy_UART, 1'b0);
        chk("cmd_idx", mv_indx, exp_idx);
      end
      M_WAIT: begin
        chk("wait_rdy", bus.cmd_rdy, 1'b0);
        chk("wait_resp", bus.resp, exp_resp);
        chk("wait_clr_uart", bus.clr_cmd_rdy_UART, 1'b0);
        chk("wait_idx", mv_indx, exp_idx);
      end
      default: ;
    endcase
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_uart();
    bus.cmd_UART     = 16'($urandom);
    bus.cmd_rdy_UART = 1'($urandom);
  endtask

  task automatic idle_traffic(input int n);
    for (int i = 0; i < n; i++) begin
      rand_uart();
      bus.clr_cmd_rdy = 1'($urandom);
      step();
    end
    bus.clr_cmd_rdy = 1'b0;
  endtask

  task automatic fill_mem();
    for (int i = 0; i < 32; i++) mem[i] = 8'(1 << $urandom_range(0, 7));
  endtask

  task automatic issue_leg(input logic [15:0] c, input int lat, input bit final_leg,
                           input bit horz, input bit do_rst, output bit ok);
    int cnt;
    int d;
    ok  = 1'b0;
    cnt = 0;
    while (bus.cmd_rdy !== 1'b1 && cnt < 8) begin
      rand_uart();
      step();
      cnt++;
    end
    chk("rdy_latency", cnt, lat);
    if (bus.cmd_rdy !== 1'b1) return;
    seen_cmds.push_back(bus.cmd);
    exp_cmd = c;
    mode    = M_CMD;
    d = $urandom_range(0, 3);
    for (int j = 0; j < d; j++) begin
      rand_uart();
      step();
    end
    // clr with an optional same-cycle send_resp that must be ignored; start_tour mid-tour must be too
    bus.clr_cmd_rdy = 1'b1;
    bus.send_resp   = ($urandom_range(0, 2) == 0);
    start_tour      = horz;
    step();
    bus.clr_cmd_rdy = 1'b0;
    bus.send_resp   = 1'b0;
    start_tour      = 1'b0;
    exp_resp = final_leg ? 8'h5A : 8'hA5;
    mode     = M_WAIT;
    if (do_rst) begin
      bus.cmd_rdy_UART = 1'b0;
      rst_n   = 1'b0;
      mode    = M_IDLE;
      exp_idx = 0;
      step();
      chk("rst_rdy", bus.cmd_rdy, 1'b0);
      chk("rst_idx", mv_indx, 0);
      chk("rst_resp", bus.resp, 8'hA5);
      rst_n = 1'b1;
      ok = 1'b1;
      return;
    end
    d = $urandom_range(0, 4);
    for (int j = 0; j < d; j++) begin
      rand_uart();
      step();
    end
    bus.send_resp = 1'b1;
    seen_resp.push_back(bus.resp);
    step();
    bus.send_resp = 1'b0;
    ok = 1'b1;
  endtask

  task automatic run_tour(input int rst_move);
    logic [7:0] m;
    int b;
    bit ok;
    seen_cmds.delete();
    seen_resp.delete();
    bus.clr_cmd_rdy = 1'b0;
    bus.send_resp   = 1'b0;
    start_tour = 1'b1;
    mode = M_TRANS;
    step();
    start_tour = 1'b0;
    exp_idx = 0;
    for (int i = 0; i < NUM_MOVES; i++) begin
      m = mem[i];
      if ($countones(m) != 1) begin
        bus.cmd_rdy_UART = 1'b0;
        chk("bad_load_rdy", bus.cmd_rdy, 1'b0);
        step();
        mode = M_IDLE;
        return;
      end
      b = 0;
      for (int k = 0; k < 8; k++) if (m[k]) b = k;
      issue_leg(vcmd(b), 1, 1'b0, 1'b0, (i == rst_move), ok);
      if (!ok) begin mode = M_OFF; return; end
      if (i == rst_move) return;
      issue_leg(hcmd(b), 0, (i == NUM_MOVES - 1), 1'b1, 1'b0, ok);
      if (!ok) begin mode = M_OFF; return; end
      if (i == NUM_MOVES - 1) begin
        mode = M_IDLE;
      end else begin
        exp_idx = i + 1;
        mode = M_TRANS;
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int acks;
    int k;
    bus.cmd_UART     = 16'h0;
    bus.cmd_rdy_UART = 1'b0;
    bus.clr_cmd_rdy  = 1'b0;
    bus.send_resp    = 1'b0;
    fill_mem();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    step();

    // Idle passthrough, literal
    bus.cmd_UART     = 16'h2005;
    bus.cmd_rdy_UART = 1'b1;
    bus.clr_cmd_rdy  = 1'b1;
    #1;
    chk("pass_cmd", bus.cmd, 16'h2005);
    chk("pass_rdy", bus.cmd_rdy, 1'b1);
    chk("pass_clr", bus.clr_cmd_rdy_UART, 1'b1);
    step();
    bus.clr_cmd_rdy = 1'b0;
    idle_traffic(20);

    // Directed first moves (bit0, bit3) inside a full tour
    fill_mem();
    mem[0] = 8'h01;
    mem[1] = 8'h08;
    run_tour(-1);
    chk("lit_cmd0", seen_cmds.size() > 0 ? seen_cmds[0] : 16'hxxxx, 16'h2002);
    chk("lit_cmd1", seen_cmds.size() > 1 ? seen_cmds[1] : 16'hxxxx, 16'h3BF1);
    chk("lit_cmd2", seen_cmds.size() > 2 ? seen_cmds[2] : 16'hxxxx, 16'h27F1);
    chk("lit_cmd3", seen_cmds.size() > 3 ? seen_cmds[3] : 16'hxxxx, 16'h33F2);
    chk("tour_ncmds", seen_cmds.size(), 48);
    chk("tour_nresp", seen_resp.size(), 48);
    acks = 0;
    for (int i = 0; i < seen_resp.size() && i < 47; i++) if (seen_resp[i] == 8'hA5) acks++;
    chk("tour_acks", acks, 47);
    chk("tour_done", seen_resp.size() == 48 ? seen_resp[47] : 8'hxx, 8'h5A);
    chk("tour_end_idx", mv_indx, 23);
    idle_traffic(10);

    // Random full tour
    fill_mem();
    run_tour(-1);
    chk("tour2_nresp", seen_resp.size(), 48);
    idle_traffic(10);

    // Bad move 8'h03 at index 1
    fill_mem();
    mem[0] = 8'h01;
    mem[1] = 8'h03;
    run_tour(-1);
    chk("bad_ncmds", seen_cmds.size(), 2);
    chk("bad_idx", mv_indx, 1);
    bus.cmd_UART     = 16'h2005;
    bus.cmd_rdy_UART = 1'b1;
    #1;
    chk("bad_pass_cmd", bus.cmd, 16'h2005);
    chk("bad_pass_rdy", bus.cmd_rdy, 1'b1);
    idle_traffic(10);

    // Zero move at a random index
    fill_mem();
    k = $urandom_range(0, NUM_MOVES - 1);
    mem[k] = 8'h00;
    run_tour(-1);
    chk("zero_ncmds", seen_cmds.size(), 2 * k);
    chk("zero_idx", mv_indx, k);
    idle_traffic(10);

    // Reset while waiting on the vertical leg's response
    fill_mem();
    k = $urandom_range(1, NUM_MOVES - 2);
    run_tour(k);
    chk("rst_ncmds", seen_cmds.size(), 2 * k + 1);
    idle_traffic(10);

    // Recovery tour after reset
    fill_mem();
    run_tour(-1);
    chk("tour3_nresp", seen_resp.size(), 48);
    chk("tour3_idx", mv_indx, 23);
    idle_traffic(5);

    mode = M_OFF;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
